// File: rtl/sram_port_ctrl_pkg.sv
// Shared constants and types for the SRAM port controller and its response FIFO.
package sram_port_ctrl_pkg;

  localparam int unsigned SRAM_RD_LAT = 1;
  localparam int unsigned RSP_DEPTH   = 2;
  localparam int unsigned RSP_CW      = $clog2(RSP_DEPTH + 1);
  localparam int unsigned RSP_PW      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Side that wins the next read/write conflict.
  typedef enum logic {
    FAV_RD = 1'b0,
    FAV_WR = 1'b1
  } rr_fav_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous response FIFO (RSP_DEPTH entries) with occupancy count.
// Simultaneous push and pop while full is allowed and leaves the count unchanged.
module sram_rsp_fifo
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic [RSP_CW-1:0] count
);

  logic [W-1:0]      mem [RSP_DEPTH];
  logic [RSP_PW-1:0] rptr;
  logic [RSP_PW-1:0] wptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [RSP_PW-1:0] next_ptr(input logic [RSP_PW-1:0] p);
    return (p == RSP_PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != RSP_CW'(RSP_DEPTH)) || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= next_ptr(wptr);
      end
      if (do_pop) rptr <= next_ptr(rptr);
      count <= count + RSP_CW'(do_push) - RSP_CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Arbitrates a write stream and a read-request stream onto one single-port SRAM and
// returns read data in order. Optional macro SRAM_RD_BYPASS_EN gives 1-cycle read latency.
module sram_port_ctrl
  import sram_port_ctrl_pkg::*;
#(
  parameter int unsigned WWORD = 32,
  parameter int unsigned WADDR = 5,
  parameter int unsigned DEPTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WADDR-1:0] wr_addr,
  input  logic [WWORD-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [WADDR-1:0] rd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WWORD-1:0] rsp_data,
  output logic [WADDR-1:0] sram_a,
  output logic             sram_cen,
  output logic             sram_wen,
  output logic [WWORD-1:0] sram_d,
  input  logic [WWORD-1:0] sram_q,
  output logic             err_oob
);

  localparam int unsigned CW1 = RSP_CW + 1;

  rr_fav_t           fav;
  logic              pend;
  logic              pend_oob;
  logic [WADDR-1:0]  a_hold;
  logic [WWORD-1:0]  d_hold;

  logic              rd_oob;
  logic              wr_oob;
  logic              rd_ok;
  logic              rd_elig;
  logic              rd_fire;
  logic              wr_fire;
  logic              rsp_pop;
  logic [CW1-1:0]    credit;

  logic              fifo_push;
  logic              fifo_pop;
  logic [WWORD-1:0]  fifo_dout;
  logic [RSP_CW-1:0] fifo_count;
  logic [WWORD-1:0]  pend_data;

  assign rd_oob  = 32'(rd_addr) >= DEPTH;
  assign wr_oob  = 32'(wr_addr) >= DEPTH;
  assign rsp_pop = rsp_valid && rsp_ready;

  // Outstanding reads (buffered + in the SRAM cycle) less the one leaving this cycle.
  assign credit  = CW1'(fifo_count) + CW1'(pend) - CW1'(rsp_pop);
  assign rd_ok   = credit < CW1'(RSP_DEPTH);
  assign rd_elig = rd_valid && rd_ok;

  always_comb begin
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    if (!rst) begin
      if (wr_valid && rd_elig) begin
        if (fav == FAV_RD) rd_fire = 1'b1;
        else               wr_fire = 1'b1;
      end else if (wr_valid) begin
        wr_fire = 1'b1;
      end else if (rd_elig) begin
        rd_fire = 1'b1;
      end
    end
  end

  assign wr_ready = wr_fire;
  assign rd_ready = rd_fire;

  // Out-of-range requests complete the handshake but never strobe the macro.
  assign sram_cen = !(rd_fire && !rd_oob);
  assign sram_wen = !(wr_fire && !wr_oob);
  assign sram_a   = rd_fire ? rd_addr : (wr_fire ? wr_addr : a_hold);
  assign sram_d   = wr_fire ? wr_data : d_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fav      <= FAV_RD;
      pend     <= 1'b0;
      pend_oob <= 1'b0;
      a_hold   <= '0;
      d_hold   <= '0;
      err_oob  <= 1'b0;
    end else begin
      pend     <= rd_fire;
      pend_oob <= rd_fire && rd_oob;
      a_hold   <= sram_a;
      d_hold   <= sram_d;
      if ((rd_fire && rd_oob) || (wr_fire && wr_oob)) err_oob <= 1'b1;
      if (wr_valid && rd_elig) fav <= rd_fire ? FAV_WR : FAV_RD;
    end
  end

  assign pend_data = pend_oob ? '0 : sram_q;

`ifdef SRAM_RD_BYPASS_EN
  logic byp;
  // Empty FIFO: present the SRAM word directly and only buffer it if not taken.
  assign byp       = pend && (fifo_count == '0);
  assign rsp_valid = (fifo_count != '0) || pend;
  assign rsp_data  = byp ? pend_data : fifo_dout;
  assign fifo_push = pend && !(byp && rsp_ready);
  assign fifo_pop  = rsp_ready && (fifo_count != '0);
`else
  assign rsp_valid = fifo_count != '0;
  assign rsp_data  = fifo_dout;
  assign fifo_push = pend;
  assign fifo_pop  = rsp_pop;
`endif

  sram_rsp_fifo #(
    .W(WWORD)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (pend_data),
    .dout (fifo_dout),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl: table vectors, directed corner sequences and
// random traffic, all checked every cycle against a transaction-level reference model.
module tb_sram_port_ctrl;

  localparam int unsigned WWORD = 32;
  localparam int unsigned WADDR = 5;
  localparam int unsigned DEPTH = 24;
`ifdef SRAM_RD_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk, rst;
  logic             wr_valid, wr_ready, rd_valid, rd_ready;
  logic [WADDR-1:0] wr_addr, rd_addr, sram_a;
  logic [WWORD-1:0] wr_data, rsp_data, sram_d, sram_q;
  logic             rsp_valid, rsp_ready, sram_cen, sram_wen, err_oob;

  sram_port_ctrl #(
    .WWORD(WWORD),
    .WADDR(WADDR),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_d(sram_d),
    .sram_q(sram_q), .err_oob(err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM macro: q valid the cycle after a cen strobe.
  logic [WWORD-1:0] sram_mem [32];
  always @(posedge clk) begin
    if (!sram_cen) sram_q <= sram_mem[sram_a];
    if (!sram_wen) sram_mem[sram_a] <= sram_d;
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory image, in-order list of expected responses with issue cycle.
  typedef struct {
    logic [WWORD-1:0] data;
    int               cyc;
  } rsp_t;

  logic [WWORD-1:0] ref_mem [32];
  rsp_t             exp_q[$];
  logic [WWORD-1:0] tbl_q[$];
  bit               fav_wr = 1'b0;
  bit               err_exp = 1'b0;
  bit               use_tbl = 1'b0;
  int               pops = 0;

  always @(negedge clk) begin
    bit ev, pop, rd_ok, rd_elig, e_rd, e_wr, r_oob, w_oob;
    if (rst) begin
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_ready", 32'(rd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_err_oob", 32'(err_oob), 32'd0);
      chk("rst_cen", 32'(sram_cen), 32'd1);
      chk("rst_wen", 32'(sram_wen), 32'd1);
      exp_q.delete();
      tbl_q.delete();
      fav_wr  = 1'b0;
      err_exp = 1'b0;
    end else begin
      ev      = exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= LAT;
      pop     = ev && rsp_ready;
      rd_ok   = (exp_q.size() - (pop ? 1 : 0)) < 2;
      rd_elig = rd_valid && rd_ok;
      e_rd    = rd_elig && !(wr_valid && fav_wr);
      e_wr    = wr_valid && !e_rd;
      r_oob   = 32'(rd_addr) >= DEPTH;
      w_oob   = 32'(wr_addr) >= DEPTH;
      chk("wr_ready", 32'(wr_ready), 32'(e_wr));
      chk("rd_ready", 32'(rd_ready), 32'(e_rd));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) chk("rsp_data", rsp_data, exp_q[0].data);
      chk("err_oob", 32'(err_oob), 32'(err_exp));
      chk("sram_cen", 32'(sram_cen), 32'(!(e_rd && !r_oob)));
      chk("sram_wen", 32'(sram_wen), 32'(!(e_wr && !w_oob)));
      if (e_rd && !r_oob) chk("sram_a_rd", 32'(sram_a), 32'(rd_addr));
      if (e_wr && !w_oob) begin
        chk("sram_a_wr", 32'(sram_a), 32'(wr_addr));
        chk("sram_d_wr", sram_d, wr_data);
      end
      if (pop) begin
        if (use_tbl && tbl_q.size() > 0) chk("tbl_rsp", rsp_data, tbl_q.pop_front());
        void'(exp_q.pop_front());
        pops++;
      end
      if (e_rd) exp_q.push_back('{data: (r_oob ? '0 : ref_mem[rd_addr]), cyc: cyc});
      if (e_wr && !w_oob) ref_mem[wr_addr] = wr_data;
      if ((e_rd && r_oob) || (e_wr && w_oob)) err_exp = 1'b1;
      if (wr_valid && rd_elig) fav_wr = e_rd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  // Waits for the pending handshake, then advances to the next cycle's drive point.
  task automatic wait_ready(input bit wr);
    int k = 0;
    forever begin
      @(negedge clk);
      if (wr ? wr_ready : rd_ready) break;
      k++;
      if (k > 20) begin
        timeout(wr ? "wr_handshake" : "rd_handshake");
        break;
      end
    end
    step();
  endtask

  task automatic drain();
    int k = 0;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    rsp_ready = 1'b1;
    while (exp_q.size() > 0 && k < 20) begin
      step();
      k++;
    end
    if (exp_q.size() > 0) timeout("drain");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit               wr;
    logic [WADDR-1:0] addr;
    logic [WWORD-1:0] data;
    logic [WWORD-1:0] exp;
  } vec_t;

  vec_t tv [24];

  initial begin
    int acc, k, pops0, cyc_a;
    logic [7:0] gseq;
    for (int i = 0; i < 32; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_q = '0;
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tv[i]     = '{1'b1, WADDR'(i), 32'h11 + 32'(i), 32'h0};
      tv[i + 8] = '{1'b0, WADDR'(i), 32'h0, 32'h11 + 32'(i)};
    end
    tv[16] = '{1'b1, 5'd25, 32'hDEAD, 32'h0};
    tv[17] = '{1'b0, 5'd25, 32'h0, 32'h0};
    tv[18] = '{1'b1, 5'd23, 32'hABCD, 32'h0};
    tv[19] = '{1'b0, 5'd23, 32'h0, 32'hABCD};
    tv[20] = '{1'b1, 5'd24, 32'h24, 32'h0};
    tv[21] = '{1'b0, 5'd24, 32'h0, 32'h0};
    tv[22] = '{1'b0, 5'd31, 32'h0, 32'h0};
    tv[23] = '{1'b0, 5'd7, 32'h0, 32'h18};

    use_tbl = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (tv[i].wr) begin
        wr_valid = 1'b1; wr_addr = tv[i].addr; wr_data = tv[i].data;
      end else begin
        rd_valid = 1'b1; rd_addr = tv[i].addr; tbl_q.push_back(tv[i].exp);
      end
      wait_ready(tv[i].wr);
      wr_valid = 1'b0;
      rd_valid = 1'b0;
    end
    drain();
    use_tbl = 1'b0;
    chk("err_sticky", 32'(err_oob), 32'd1);

    // Simultaneous requests after reset: read wins first, then strict alternation.
    do_reset();
    gseq = '0;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hA0;
    rd_valid = 1'b1; rd_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gseq = {gseq[5:0], wr_ready, rd_ready};
      step();
      wr_data = wr_data + 1;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("conflict_seq", 32'(gseq), 32'h66);
    drain();

    // Backpressure: only two reads may be outstanding while responses are stalled.
    pops0 = pops;
    acc = 0;
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 5'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_ready) acc++;
      step();
      rd_addr = WADDR'(acc);
    end
    chk("bp_accepted_stalled", 32'(acc), 32'd2);
    rsp_ready = 1'b1;
    k = 0;
    while (acc < 4 && k < 10) begin
      @(negedge clk);
      if (rd_ready) acc++;
      step();
      rd_addr = WADDR'(acc);
      if (acc == 4) rd_valid = 1'b0;
      k++;
    end
    rd_valid = 1'b0;
    chk("bp_accepted_total", 32'(acc), 32'd4);
    drain();
    chk("bp_responses", 32'(pops - pops0), 32'd4);

    // Reset while responses are outstanding drops them and clears the error flag.
    rsp_ready = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd26; wr_data = 32'h5A5A;
    wait_ready(1'b1);
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 5'd0;
    wait_ready(1'b0);
    rd_addr = 5'd1;
    wait_ready(1'b0);
    rd_valid = 1'b0;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_err", 32'(err_oob), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_err", 32'(err_oob), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    pops0 = pops;
    repeat (6) step();
    chk("no_stale_rsp", 32'(pops - pops0), 32'd0);

`ifdef SRAM_RD_BYPASS_EN
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    wait_ready(1'b1);
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 5'd3;
    @(negedge clk);
    cyc_a = cyc;
    step();
    rd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      step();
      k++;
    end
    @(negedge clk);
    chk("byp_latency", 32'(cyc - cyc_a), 32'd1);
    chk("byp_data", rsp_data, 32'h33);
    drain();
`else
    cyc_a = 0;
`endif

    // Random traffic, including out-of-range addresses and response stalls.
    for (int i = 0; i < 400; i++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      rd_valid  = 1'($urandom_range(0, 1));
      wr_addr   = WADDR'($urandom_range(0, 31));
      rd_addr   = WADDR'($urandom_range(0, 31));
      wr_data   = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
